division_seq_param: RTL and testbench

- Parameterised multi-cycle restoring divider; the next generation of the 8-bit start/done divider on the Basys3 logic-design board.
- Adds:
  - configurable width
  - run-time signed/unsigned mode
  - divide-by-zero and overflow flags
  - busy indication
  - edge-triggered start
- Sits between switch/button input logic and the LED/seven-segment display logic. Results are held stable for display until the next operation.

---
 rtl/division_pkg.sv | 40 ++++
 rtl/division_step.sv | 36 +++
 rtl/division_seq_param.sv | 167 ++++++++++++++++
 tb/tb_division_seq_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/division_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents:
//   MAX_W    - widest operand the helper functions handle (32 bits)
//   state_t  - control FSM states (IDLE, LOAD, CALC, FIX, DONE)
//   abs_val  - magnitude of an operand in signed or unsigned mode
//   neg_if   - conditional two's-complement negation
// The helpers work on MAX_W-bit vectors. Callers zero-extend their WIDTH-bit
// operand and truncate the result back to WIDTH bits. The low WIDTH bits of a
// two's-complement negation do not depend on the upper bits, so this is exact.
package division_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // msb is the operand's own sign bit (bit WIDTH-1 at the caller's width).
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                 input logic             signed_en,
                                                 input logic             msb);
        if (signed_en && msb) begin
            return ~x + MAX_W'(1);
        end
        return x;
    endfunction

    function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] x,
                                                input logic             cond);
        if (cond) begin
            return ~x + MAX_W'(1);
        end
        return x;
    endfunction

endpackage

// File: rtl/division_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem_in   - partial remainder before this step (always < divisor)
//   quo_in   - dividend/quotient shift register before this step
//   divisor  - divisor magnitude
//   rem_out  - partial remainder after this step
//   quo_out  - shift register after this step; the new quotient bit is in the LSB
// The shifted remainder is WIDTH+1 bits wide. It can reach 2*divisor-1, which
// does not fit in WIDTH bits. The trial difference carries one more bit so
// that its sign is unambiguous.
module division_step
    import division_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             fits;

    always_comb begin
        rem_sh  = {rem_in, quo_in[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, divisor};
        fits    = ~diff[WIDTH+1];
        // A restored remainder is below the divisor, so its top bit is zero.
        rem_out = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/division_seq_param.sv
// Parameterised multi-cycle restoring divider with run-time signed/unsigned mode.
// Ports:
//   sys_clock   - clock, rising edge
//   reset_n     - asynchronous active-low reset
//   start       - request; only a rising edge seen in IDLE launches an operation
//   signed_op   - 1 = two's-complement operands; latched with the operands
//   dividend_in - dividend
//   divisor_in  - divisor
//   busy        - high from the accept edge until the done cycle ends
//   done        - one-cycle pulse when the results are valid
//   Quotient    - quotient; held until the next result is written
//   Remainder   - remainder; held until the next result is written
//   div_by_zero - divisor was zero; cleared on the next accept
//   overflow    - signed MIN / -1; cleared on the next accept
// Handshake: an operation is accepted on the edge where start is high, start
// was low on the previous edge, and the FSM is in IDLE. Edges seen while busy
// are dropped, not queued. done is asserted for exactly one cycle per
// accepted operation. Quotient and Remainder stay stable from done until the
// next operation writes new results.
module division_seq_param
    import division_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             sys_clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, next_state;

    logic             start_q;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_signed;
    logic [WIDTH-1:0] rem_r, quo_r, div_r;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             zero_div, ovf_case;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign accept = start & ~start_q & (state == IDLE);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_comb begin
        mag_a    = WIDTH'(abs_val(MAX_W'(op_a), op_signed, op_a[WIDTH-1]));
        mag_b    = WIDTH'(abs_val(MAX_W'(op_b), op_signed, op_b[WIDTH-1]));
        zero_div = (op_b == '0);
        ovf_case = op_signed && (op_a == MIN_VAL) && (op_b == '1);
        // The sign registers are only set in signed mode, so they gate the fix-up.
        quo_fix  = WIDTH'(neg_if(MAX_W'(quo_r), sign_q));
        rem_fix  = WIDTH'(neg_if(MAX_W'(rem_r), sign_r));
    end

    division_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .divisor (div_r),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    // State register
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = LOAD;
            LOAD: begin
                if (zero_div || ovf_case) begin
                    next_state = DONE;
                end else begin
                    next_state = CALC;
                end
            end
            CALC: if (cnt == CNT_W'(1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q     <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_signed   <= 1'b0;
            rem_r       <= '0;
            quo_r       <= '0;
            div_r       <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a        <= dividend_in;
                        op_b        <= divisor_in;
                        op_signed   <= signed_op;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                LOAD: begin
                    quo_r  <= mag_a;
                    div_r  <= mag_b;
                    rem_r  <= '0;
                    cnt    <= CNT_W'(WIDTH);
                    sign_q <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    sign_r <= op_signed & op_a[WIDTH-1];
                    if (zero_div) begin
                        Quotient    <= '1;
                        Remainder   <= op_a;
                        div_by_zero <= 1'b1;
                    end else if (ovf_case) begin
                        Quotient  <= MIN_VAL;
                        Remainder <= '0;
                        overflow  <= 1'b1;
                    end
                end
                CALC: begin
                    rem_r <= rem_next;
                    quo_r <= quo_next;
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    Quotient  <= quo_fix;
                    Remainder <= rem_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_seq_param.sv
module tb_division_seq_param;

    logic        sys_clock;
    logic        reset_n;

    logic        start8, signed8;
    logic [7:0]  dividend8, divisor8;
    logic        busy8, done8, dbz8, ovf8;
    logic [7:0]  quo8, rem8;

    logic        start16, signed16;
    logic [15:0] dividend16, divisor16;
    logic        busy16, done16, dbz16, ovf16;
    logic [15:0] quo16, rem16;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int ndone;

    division_seq_param #(.WIDTH(8)) dut8 (
        .sys_clock   (sys_clock),
        .reset_n     (reset_n),
        .start       (start8),
        .signed_op   (signed8),
        .dividend_in (dividend8),
        .divisor_in  (divisor8),
        .busy        (busy8),
        .done        (done8),
        .Quotient    (quo8),
        .Remainder   (rem8),
        .div_by_zero (dbz8),
        .overflow    (ovf8)
    );

    division_seq_param #(.WIDTH(16)) dut16 (
        .sys_clock   (sys_clock),
        .reset_n     (reset_n),
        .start       (start16),
        .signed_op   (signed16),
        .dividend_in (dividend16),
        .divisor_in  (divisor16),
        .busy        (busy16),
        .done        (done16),
        .Quotient    (quo16),
        .Remainder   (rem16),
        .div_by_zero (dbz16),
        .overflow    (ovf16)
    );

    // Clock
    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one 8-bit operation and return the edge count (accept edge = 1)
    // at which done was seen; 0 means done never came within the budget.
    // hold: edge after which start is dropped (0 = leave start high).
    // repulse: edge at which a one-cycle start pulse is re-issued (0 = none).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        input int hold, input int repulse, output int edges);
        @(posedge sys_clock); #1;
        dividend8 = a;
        divisor8  = b;
        signed8   = sgn;
        start8    = 1'b1;
        edges     = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge sys_clock); #1;
            if (i == 1) check("busy_after_accept", busy8, 1);
            if (hold > 0 && i == hold) start8 = 1'b0;
            if (repulse > 0 && i == repulse) start8 = 1'b1;
            if (repulse > 0 && i == repulse + 1) start8 = 1'b0;
            if (done8) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic count_done8(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge sys_clock); #1;
            if (done8) c++;
        end
    endtask

    task automatic check_after_done8;
        @(posedge sys_clock); #1;
        check("done_one_cycle", done8, 0);
        check("busy_low_after", busy8, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        start8     = 1'b0;
        signed8    = 1'b0;
        dividend8  = '0;
        divisor8   = '0;
        start16    = 1'b0;
        signed16   = 1'b0;
        dividend16 = '0;
        divisor16  = '0;
        repeat (3) @(posedge sys_clock);
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_quo", quo8, 0);
        check("rst_rem", rem8, 0);
        check("rst_dbz", dbz8, 0);
        check("rst_ovf", ovf8, 0);
        reset_n = 1'b1;

        // 11/3, start held for two cycles
        run8(8'd11, 8'd3, 1'b0, 2, 0, lat);
        check("u11_3_lat", lat, 11);
        check("u11_3_q", quo8, 3);
        check("u11_3_r", rem8, 2);
        check("u11_3_dbz", dbz8, 0);
        check("u11_3_ovf", ovf8, 0);
        check_after_done8();

        // start left high: one operation only
        run8(8'd11, 8'd3, 1'b0, 0, 0, lat);
        check("held_lat", lat, 11);
        count_done8(20, ndone);
        check("held_no_retrigger", ndone, 0);
        check("held_busy", busy8, 0);
        start8 = 1'b0;

        run8(8'd7, 8'd128, 1'b0, 1, 0, lat);
        check("u7_128_q", quo8, 0);
        check("u7_128_r", rem8, 7);
        run8(8'd252, 8'd7, 1'b0, 1, 0, lat);
        check("u252_7_q", quo8, 36);
        check("u252_7_r", rem8, 0);
        run8(8'd7, 8'd7, 1'b0, 1, 0, lat);
        check("u7_7_q", quo8, 1);
        check("u7_7_r", rem8, 0);
        check("u7_7_flags", {dbz8, ovf8}, 0);

        // Unsigned mode treats MSB as magnitude: 0xF9/0x02 = 249/2
        run8(8'hF9, 8'h02, 1'b0, 1, 0, lat);
        check("u249_2_q", quo8, 124);
        check("u249_2_r", rem8, 1);

        // Signed
        run8(8'hF9, 8'h02, 1'b1, 1, 0, lat);
        check("s_m7_2_lat", lat, 11);
        check("s_m7_2_q", quo8, 8'hFD);
        check("s_m7_2_r", rem8, 8'hFF);
        run8(8'h07, 8'hFE, 1'b1, 1, 0, lat);
        check("s_7_m2_q", quo8, 8'hFD);
        check("s_7_m2_r", rem8, 8'h01);
        run8(8'h80, 8'hFF, 1'b1, 1, 0, lat);
        check("s_ovf_lat", lat, 2);
        check("s_ovf_q", quo8, 8'h80);
        check("s_ovf_r", rem8, 0);
        check("s_ovf_flag", ovf8, 1);
        check("s_ovf_dbz", dbz8, 0);
        check_after_done8();

        // Divide by zero
        run8(8'd200, 8'd0, 1'b0, 1, 0, lat);
        check("dbz_lat", lat, 2);
        check("dbz_flag", dbz8, 1);
        check("dbz_ovf", ovf8, 0);
        check("dbz_q", quo8, 8'hFF);
        check("dbz_r", rem8, 200);
        count_done8(3, ndone);
        check("dbz_flag_held", dbz8, 1);
        run8(8'd9, 8'd4, 1'b0, 1, 0, lat);
        check("after_dbz_flag", dbz8, 0);
        check("after_dbz_q", quo8, 2);
        check("after_dbz_r", rem8, 1);

        // Start pulse during CALC is ignored
        run8(8'd200, 8'd7, 1'b0, 1, 4, lat);
        check("pulse_lat", lat, 11);
        check("pulse_q", quo8, 28);
        check("pulse_r", rem8, 4);
        count_done8(20, ndone);
        check("pulse_no_second_done", ndone, 0);

        // Reset in the middle of CALC
        @(posedge sys_clock); #1;
        dividend8 = 8'd252;
        divisor8  = 8'd7;
        signed8   = 1'b0;
        start8    = 1'b1;
        repeat (5) begin
            @(posedge sys_clock); #1;
            start8 = 1'b0;
        end
        check("mid_busy", busy8, 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_q", quo8, 0);
        check("abort_r", rem8, 0);
        count_done8(15, ndone);
        check("abort_no_done", ndone, 0);
        reset_n = 1'b1;
        count_done8(15, ndone);
        check("abort_no_done_after", ndone, 0);
        run8(8'd100, 8'd9, 1'b0, 1, 0, lat);
        check("u100_9_lat", lat, 11);
        check("u100_9_q", quo8, 11);
        check("u100_9_r", rem8, 1);

        // 16-bit instance: 60000/7
        @(posedge sys_clock); #1;
        dividend16 = 16'd60000;
        divisor16  = 16'd7;
        signed16   = 1'b0;
        start16    = 1'b1;
        lat        = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge sys_clock); #1;
            start16 = 1'b0;
            if (done16) begin
                lat = i;
                break;
            end
        end
        check("w16_lat", lat, 19);
        check("w16_q", quo16, 8571);
        check("w16_r", rem16, 3);
        check("w16_flags", {dbz16, ovf16}, 0);
        @(posedge sys_clock); #1;
        check("w16_busy_after", busy16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
